// File: rtl/free_play_engine.sv
// free_play_engine: free-play note engine. Edge-detected strike and octave
// step inputs, IDLE/PLAY/GAP note FSM with retrigger, one-hot key LEDs and a
// note-end pulse. Optional strike recorder FIFO enabled by FREE_PLAY_REC_EN.
module free_play_engine #(
    parameter int NUM_KEYS  = 7,
    parameter int OCT_MIN   = 1,
    parameter int OCT_MAX   = 7,
    parameter int OCT_INIT  = 4,
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_CYC   = 1000000,
    parameter int REC_DEPTH = 16,
    localparam int NW = $clog2(NUM_KEYS + 1),
    localparam int RW = 3 + NW + 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                hit,
    input  logic                oct_up,
    input  logic                oct_down,
    input  logic [NUM_KEYS-1:0] note_key,
    input  logic [3:0]          length_key,
    output logic [NW-1:0]       note,
    output logic [2:0]          octave,
    output logic [3:0]          length,
    output logic                play,
    output logic [NUM_KEYS-1:0] led,
    output logic                done,
    input  logic                rec_rd,
    output logic [RW-1:0]       rec_data,
    output logic                rec_empty,
    output logic                rec_full,
    output logic                rec_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [2:0]    OCT_INIT_V = 3'(OCT_INIT);
    localparam logic [2:0]    OCT_MIN_V  = 3'(OCT_MIN);
    localparam logic [2:0]    OCT_MAX_V  = 3'(OCT_MAX);

    logic          hit_q_r, up_q_r, dn_q_r;
    logic          hit_edge_s, up_edge_s, dn_edge_s, strike_s;
    logic [1:0]    state_r, state_nxt_s;
    logic [2:0]    sel_oct_r, sel_oct_nxt_s;
    logic [2:0]    note_oct_r, note_oct_nxt_s;
    logic [NW-1:0] key_note_s, note_nxt_s;
    logic [3:0]    len_sel_s, length_nxt_s;
    logic [3:0]    unit_cnt_r, unit_nxt_s;
    logic [TW-1:0] tick_cnt_r, tick_nxt_s;
    logic [GW-1:0] gap_cnt_r, gap_nxt_s;
    logic          done_nxt_s, play_nxt_s;
    logic [NUM_KEYS-1:0] led_nxt_s;
    logic [2:0]    octave_nxt_s;

    assign hit_edge_s = hit & ~hit_q_r;
    assign up_edge_s  = oct_up & ~up_q_r;
    assign dn_edge_s  = oct_down & ~dn_q_r;
    assign strike_s   = en & hit_edge_s & (|note_key);

    // Previous-cycle copies of the level inputs for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q_r <= 1'b0;
            up_q_r  <= 1'b0;
            dn_q_r  <= 1'b0;
        end else begin
            hit_q_r <= hit;
            up_q_r  <= oct_up;
            dn_q_r  <= oct_down;
        end
    end

    // Lowest pressed key wins; note code is key index + 1.
    always_comb begin
        key_note_s = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            key_note_s = note_key[i] ? NW'(i + 1) : key_note_s;
        end
    end

    // Length from the highest set length_key bit; nothing pressed means 2 units.
    always_comb begin
        if (length_key[3])      len_sel_s = 4'd8;
        else if (length_key[2]) len_sel_s = 4'd4;
        else if (length_key[1]) len_sel_s = 4'd2;
        else if (length_key[0]) len_sel_s = 4'd1;
        else                    len_sel_s = 4'd2;
    end

    // Octave selector: saturating step, simultaneous up/down cancels.
    always_comb begin
        if (!en)
            sel_oct_nxt_s = OCT_INIT_V;
        else if (up_edge_s && !dn_edge_s && (sel_oct_r != OCT_MAX_V))
            sel_oct_nxt_s = sel_oct_r + 3'd1;
        else if (dn_edge_s && !up_edge_s && (sel_oct_r != OCT_MIN_V))
            sel_oct_nxt_s = sel_oct_r - 3'd1;
        else
            sel_oct_nxt_s = sel_oct_r;
    end

    // Note FSM next state; a valid strike always (re)starts PLAY.
    always_comb begin
        state_nxt_s    = state_r;
        note_nxt_s     = note;
        note_oct_nxt_s = note_oct_r;
        length_nxt_s   = length;
        tick_nxt_s     = tick_cnt_r;
        unit_nxt_s     = unit_cnt_r;
        gap_nxt_s      = gap_cnt_r;
        done_nxt_s     = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
            note_nxt_s  = '0;
            tick_nxt_s  = '0;
            unit_nxt_s  = 4'd0;
            gap_nxt_s   = '0;
        end else if (strike_s) begin
            state_nxt_s    = ST_PLAY;
            note_nxt_s     = key_note_s;
            note_oct_nxt_s = sel_oct_r;
            length_nxt_s   = len_sel_s;
            tick_nxt_s     = '0;
            unit_nxt_s     = 4'd0;
            gap_nxt_s      = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_PLAY: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_nxt_s = '0;
                        if (unit_cnt_r == (length - 4'd1)) begin
                            state_nxt_s = ST_GAP;
                            unit_nxt_s  = 4'd0;
                            gap_nxt_s   = '0;
                            done_nxt_s  = 1'b1;
                        end else begin
                            unit_nxt_s = unit_cnt_r + 4'd1;
                        end
                    end else begin
                        tick_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_nxt_s = ST_IDLE;
                        gap_nxt_s   = '0;
                    end else begin
                        gap_nxt_s = gap_cnt_r + GAP_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    note_nxt_s  = '0;
                end
            endcase
        end
    end

    // Output decode: octave shows the latched note octave while a note is active.
    always_comb begin
        play_nxt_s   = (state_nxt_s == ST_PLAY);
        octave_nxt_s = (state_nxt_s == ST_IDLE) ? sel_oct_nxt_s : note_oct_nxt_s;
        led_nxt_s    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            led_nxt_s[i] = play_nxt_s && (note_nxt_s == NW'(i + 1));
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sel_oct_r  <= OCT_INIT_V;
            note_oct_r <= OCT_INIT_V;
            note       <= '0;
            length     <= 4'd0;
            tick_cnt_r <= '0;
            unit_cnt_r <= 4'd0;
            gap_cnt_r  <= '0;
            done       <= 1'b0;
            play       <= 1'b0;
            led        <= '0;
            octave     <= OCT_INIT_V;
        end else begin
            state_r    <= state_nxt_s;
            sel_oct_r  <= sel_oct_nxt_s;
            note_oct_r <= note_oct_nxt_s;
            note       <= note_nxt_s;
            length     <= length_nxt_s;
            tick_cnt_r <= tick_nxt_s;
            unit_cnt_r <= unit_nxt_s;
            gap_cnt_r  <= gap_nxt_s;
            done       <= done_nxt_s;
            play       <= play_nxt_s;
            led        <= led_nxt_s;
            octave     <= octave_nxt_s;
        end
    end

`ifdef FREE_PLAY_REC_EN
    localparam int AW = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [RW-1:0] rec_mem_r [REC_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic          pop_s, push_s;
    logic [RW-1:0] push_data_s;

    assign rec_empty   = (wr_ptr_r == rd_ptr_r);
    assign rec_full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s       = rec_rd & ~rec_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s      = strike_s & (~rec_full | pop_s);
    assign push_data_s = {sel_oct_r, key_note_s, len_sel_s};
    assign rec_data    = rec_mem_r[rd_ptr_r[AW-1:0]];

    // Recorder pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            rec_ovf  <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (strike_s && rec_full && !pop_s) rec_ovf <= 1'b1;
        end
    end

    // Recorder storage; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) rec_mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
    end
`else
    assign rec_data  = '0;
    assign rec_empty = 1'b1;
    assign rec_full  = 1'b0;
    // rec_rd has no effect without the recorder; it is masked to a constant 0.
    assign rec_ovf   = rec_rd & 1'b0;
`endif

endmodule

// File: tb/tb_free_play_engine.sv
// Self-checking bench for free_play_engine (TICK_DIV=4, GAP_CYC=3, REC_DEPTH=4).
// Note scoreboard: expected {octave,note,length} pushed on each strike, popped
// when the note starts sounding. Recorder model queue checked when popped.
module tb_free_play_engine;
    localparam int NK = 7;
    localparam int NW = 3;
    localparam int RW = 10;
    localparam int TD = 4;
    localparam int GC = 3;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1, hit = 1'b0, oct_up = 1'b0, oct_down = 1'b0, rec_rd = 1'b0;
    logic [NK-1:0] note_key = '0;
    logic [3:0] length_key = 4'd0;
    logic [NW-1:0] note;
    logic [2:0] octave;
    logic [3:0] length;
    logic play, done, rec_empty, rec_full, rec_ovf;
    logic [NK-1:0] led;
    logic [RW-1:0] rec_data;

    typedef struct { logic [2:0] oct; logic [NW-1:0] note; logic [3:0] len; } exp_t;
    exp_t note_q[$];
    logic [RW-1:0] rec_q[$];

    int checks = 0, failures = 0, done_cnt = 0;
    int model_oct = 4;
    bit model_ovf = 1'b0;
    int cur_len = 0;

    free_play_engine #(.NUM_KEYS(NK), .OCT_MIN(1), .OCT_MAX(7), .OCT_INIT(4),
        .TICK_DIV(TD), .GAP_CYC(GC), .REC_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hit(hit), .oct_up(oct_up),
        .oct_down(oct_down), .note_key(note_key), .length_key(length_key),
        .note(note), .octave(octave), .length(length), .play(play), .led(led),
        .done(done), .rec_rd(rec_rd), .rec_data(rec_data), .rec_empty(rec_empty),
        .rec_full(rec_full), .rec_ovf(rec_ovf));

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strike(input logic [NK-1:0] keys, input logic [3:0] lkey, input int exp_len, input bit track);
        int n;
        exp_t e;
        n = 0;
        for (int i = NK - 1; i >= 0; i--) if (keys[i]) n = i + 1;
        if (en && n != 0) begin
            e.oct = 3'(model_oct); e.note = NW'(n); e.len = 4'(exp_len);
            if (track) note_q.push_back(e);
            if (rec_q.size() < RD) rec_q.push_back({e.oct, e.note, e.len});
            else model_ovf = 1'b1;
        end
        note_key = keys; length_key = lkey; hit = 1'b1;
        tick;
        hit = 1'b0;
    endtask

    task automatic pulse_oct(input bit up, input bit dn);
        if (en) begin
            if (up && !dn && model_oct < 7) model_oct++;
            else if (dn && !up && model_oct > 1) model_oct--;
        end
        oct_up = up; oct_down = dn;
        tick;
        oct_up = 1'b0; oct_down = 1'b0;
        tick;
    endtask

    task automatic check_start(input string nm);
        exp_t e;
        logic [NK-1:0] exp_led;
        checks++;
        if (note_q.size() == 0) begin
            failures++; $display("FAIL %s_sb: got empty scoreboard expected entry", nm);
            return;
        end
        e = note_q.pop_front();
        cur_len = int'(e.len);
        exp_led = 7'd1;
        exp_led = exp_led << (e.note - 3'd1);
        checks++; if (play !== 1'b1) begin failures++; $display("FAIL %s_play: got %0b expected 1", nm, play); end
        checks++; if (note !== e.note) begin failures++; $display("FAIL %s_note: got %0d expected %0d", nm, note, e.note); end
        checks++; if (octave !== e.oct) begin failures++; $display("FAIL %s_oct: got %0d expected %0d", nm, octave, e.oct); end
        checks++; if (length !== e.len) begin failures++; $display("FAIL %s_len: got %0d expected %0d", nm, length, e.len); end
        checks++; if (led !== exp_led) begin failures++; $display("FAIL %s_led: got %b expected %b", nm, led, exp_led); end
    endtask

    // Counts the remaining play cycles, then checks done and the silent gap.
    task automatic check_rest(input int already, input string nm);
        int pc, gz;
        pc = already;
        for (int g = 0; g < 200 && play === 1'b1; g++) begin
            tick;
            if (play === 1'b1) pc++;
        end
        checks++; if (pc != cur_len * TD) begin failures++; $display("FAIL %s_dur: got %0d expected %0d", nm, pc, cur_len * TD); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done: got %0b expected 1", nm, done); end
        gz = (play === 1'b0 && led === '0) ? 1 : 0;
        for (int g = 1; g < GC; g++) begin
            tick;
            if (play === 1'b0 && done === 1'b0 && led === '0) gz++;
        end
        checks++; if (gz != GC) begin failures++; $display("FAIL %s_gap: got %0d expected %0d", nm, gz, GC); end
        tick;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        note_q.delete(); rec_q.delete(); model_ovf = 1'b0; model_oct = 4;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++; if (note !== 3'd0) begin failures++; $display("FAIL rst_note: got %0d expected 0", note); end
        checks++; if (octave !== 3'd4) begin failures++; $display("FAIL rst_oct: got %0d expected 4", octave); end
        checks++; if (length !== 4'd0) begin failures++; $display("FAIL rst_len: got %0d expected 0", length); end
        checks++; if (play !== 1'b0 || done !== 1'b0 || led !== '0) begin failures++; $display("FAIL rst_outs: got play=%0b done=%0b led=%b expected 0", play, done, led); end
        checks++; if (rec_empty !== 1'b1 || rec_full !== 1'b0 || rec_ovf !== 1'b0) begin failures++; $display("FAIL rst_rec: got e=%0b f=%0b o=%0b expected 1 0 0", rec_empty, rec_full, rec_ovf); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        strike(7'b0000100, 4'b0010, 2, 1'b1);
        check_start("basic");
        check_rest(1, "basic");
        note_key = '0; hit = 1'b1;
        tick;
        hit = 1'b0;
        checks++; if (play !== 1'b0 || led !== '0) begin failures++; $display("FAIL nokey_hit: got play=%0b expected 0", play); end
        tick;
    endtask

    task automatic test_length;
        logic [3:0] lk [5] = '{4'b0001, 4'b0000, 4'b0101, 4'b1000, 4'b1111};
        int ln [5] = '{1, 2, 4, 8, 8};
        logic [NK-1:0] ks [5] = '{7'b1000000, 7'b0110000, 7'b0000010, 7'b1111111, 7'b0001000};
        for (int i = 0; i < 5; i++) begin
            strike(ks[i], lk[i], ln[i], 1'b1);
            check_start("length");
            check_rest(1, "length");
        end
    endtask

    task automatic test_octave;
        for (int i = 0; i < 5; i++) pulse_oct(1'b1, 1'b0);
        checks++; if (octave !== 3'd7) begin failures++; $display("FAIL oct_up_sat: got %0d expected 7", octave); end
        pulse_oct(1'b1, 1'b1);
        checks++; if (octave !== 3'd7) begin failures++; $display("FAIL oct_both: got %0d expected 7", octave); end
        for (int i = 0; i < 7; i++) pulse_oct(1'b0, 1'b1);
        checks++; if (octave !== 3'd1) begin failures++; $display("FAIL oct_dn_sat: got %0d expected 1", octave); end
        for (int i = 0; i < 3; i++) pulse_oct(1'b1, 1'b0);
        checks++; if (octave !== 3'(model_oct)) begin failures++; $display("FAIL oct_back: got %0d expected %0d", octave, model_oct); end
    endtask

    task automatic test_oct_during_play;
        strike(7'b0000001, 4'b0010, 2, 1'b1);
        check_start("octplay");
        pulse_oct(1'b1, 1'b0);
        checks++; if (octave !== 3'd4) begin failures++; $display("FAIL octplay_latched: got %0d expected 4", octave); end
        check_rest(3, "octplay");
        checks++; if (octave !== 3'(model_oct)) begin failures++; $display("FAIL octplay_idle: got %0d expected %0d", octave, model_oct); end
        pulse_oct(1'b0, 1'b1);
    endtask

    task automatic test_retrigger;
        int d0;
        d0 = done_cnt;
        strike(7'b0000100, 4'b0010, 2, 1'b1);
        check_start("retrig_a");
        tick; tick;
        strike(7'b0000001, 4'b0001, 1, 1'b1);
        check_start("retrig_b");
        check_rest(1, "retrig_b");
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL retrig_done_cnt: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_enable;
        int d0;
        pulse_oct(1'b1, 1'b0); pulse_oct(1'b1, 1'b0);
        strike(7'b0010000, 4'b0001, 1, 1'b1);
        check_start("en");
        tick;
        d0 = done_cnt;
        en = 1'b0;
        model_oct = 4;
        tick;
        checks++; if (play !== 1'b0 || led !== '0) begin failures++; $display("FAIL en_off_play: got play=%0b led=%b expected 0", play, led); end
        checks++; if (octave !== 3'd4) begin failures++; $display("FAIL en_off_oct: got %0d expected 4", octave); end
        checks++; if (note !== 3'd0) begin failures++; $display("FAIL en_off_note: got %0d expected 0", note); end
        strike(7'b0000001, 4'b0001, 1, 1'b0);
        tick;
        checks++; if (play !== 1'b0 || note !== 3'd0) begin failures++; $display("FAIL en_off_hit: got play=%0b note=%0d expected 0 0", play, note); end
        pulse_oct(1'b1, 1'b0);
        checks++; if (octave !== 3'd4) begin failures++; $display("FAIL en_off_octup: got %0d expected 4", octave); end
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL en_off_done: got %0d expected %0d", done_cnt, d0); end
        en = 1'b1;
        tick; tick;
    endtask

    task automatic test_reset_mid_note;
        int d0;
        strike(7'b0000010, 4'b0100, 4, 1'b0);
        tick; tick;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if (play !== 1'b0 || note !== 3'd0 || led !== '0) begin failures++; $display("FAIL rst_mid_outs: got play=%0b note=%0d expected 0 0", play, note); end
        note_q.delete(); rec_q.delete(); model_ovf = 1'b0; model_oct = 4;
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick;
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL rst_mid_done: got %0d expected %0d", done_cnt, d0); end
    endtask

    task automatic test_recorder;
        logic [RW-1:0] exp_d;
        do_reset;
`ifdef FREE_PLAY_REC_EN
        for (int i = 0; i < 5; i++) begin
            strike(7'(1 << i), 4'(1 << (i % 4)), 1 << (i % 4), 1'b0);
            tick;
        end
        checks++; if (rec_full !== 1'b1) begin failures++; $display("FAIL rec_full: got %0b expected 1", rec_full); end
        checks++; if (rec_ovf !== model_ovf) begin failures++; $display("FAIL rec_ovf: got %0b expected %0b", rec_ovf, model_ovf); end
        for (int i = 0; i < 4; i++) begin
            exp_d = rec_q.pop_front();
            checks++; if (rec_data !== exp_d) begin failures++; $display("FAIL rec_pop%0d: got %h expected %h", i, rec_data, exp_d); end
            rec_rd = 1'b1; tick; rec_rd = 1'b0;
        end
        checks++; if (rec_empty !== 1'b1 || rec_full !== 1'b0) begin failures++; $display("FAIL rec_drained: got e=%0b f=%0b expected 1 0", rec_empty, rec_full); end
        rec_rd = 1'b1; tick; rec_rd = 1'b0;
        checks++; if (rec_empty !== 1'b1) begin failures++; $display("FAIL rec_rd_empty: got %0b expected 1", rec_empty); end
        for (int i = 0; i < 4; i++) begin
            strike(7'(1 << (6 - i)), 4'b0001, 1, 1'b0);
            tick;
        end
        exp_d = rec_q.pop_front();
        checks++; if (rec_data !== exp_d) begin failures++; $display("FAIL rec_head_full: got %h expected %h", rec_data, exp_d); end
        rec_rd = 1'b1;
        strike(7'b0000001, 4'b1000, 8, 1'b0);
        rec_rd = 1'b0;
        checks++; if (rec_full !== 1'b1) begin failures++; $display("FAIL rec_pushpop_full: got %0b expected 1", rec_full); end
        checks++; if (rec_data !== rec_q[0]) begin failures++; $display("FAIL rec_pushpop_head: got %h expected %h", rec_data, rec_q[0]); end
        for (int i = 0; i < 3; i++) begin rec_rd = 1'b1; tick; end
        rec_rd = 1'b0;
        exp_d = rec_q[3];
        checks++; if (rec_data !== exp_d) begin failures++; $display("FAIL rec_pushpop_tail: got %h expected %h", rec_data, exp_d); end
        checks++; if (rec_ovf !== 1'b1) begin failures++; $display("FAIL rec_ovf_sticky: got %0b expected 1", rec_ovf); end
`else
        for (int i = 0; i < 5; i++) begin
            strike(7'(1 << i), 4'b0001, 1, 1'b0);
            tick;
        end
        rec_rd = 1'b1; tick; rec_rd = 1'b0;
        checks++; if (rec_empty !== 1'b1 || rec_full !== 1'b0) begin failures++; $display("FAIL norec_flags: got e=%0b f=%0b expected 1 0", rec_empty, rec_full); end
        checks++; if (rec_ovf !== 1'b0 || rec_data !== '0) begin failures++; $display("FAIL norec_data: got o=%0b d=%h expected 0 0", rec_ovf, rec_data); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_length;
        test_octave;
        test_oct_during_play;
        test_retrigger;
        test_enable;
        test_reset_mid_note;
        test_recorder;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/free_play_engine.md
FREE_PLAY_ENGINE -- requirements
Module: free_play_engine

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 7, number of note keys and LEDs.
REQ-002 SHALL have parameter OCT_MIN, default 1, lowest selectable octave.
REQ-003 SHALL have parameter OCT_MAX, default 7, highest selectable octave.
REQ-004 SHALL have parameter OCT_INIT, default 4, octave after reset or disable.
REQ-005 SHALL have parameter TICK_DIV, default 25000000, clk cycles per length unit.
REQ-006 SHALL have parameter GAP_CYC, default 1000000, silent articulation cycles after each note.
REQ-007 SHALL have parameter REC_DEPTH, default 16, power of two, record buffer depth.
REQ-008 SHALL have port clk, in, 1, single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-010 SHALL have ports: en in 1, block enable; hit in 1, strike request (level); oct_up / oct_down in 1, octave step (level).
REQ-011 SHALL have ports note_key in NUM_KEYS (one bit per key) and length_key in 4 (one-hot length select).
REQ-012 SHALL have ports: note out clog2(NUM_KEYS+1) (0 = rest, k+1 = key k); octave out 3; length out 4 (units); play out 1; led out NUM_KEYS; done out 1 (note-end pulse).
REQ-013 SHALL have ports rec_rd in 1, rec_data out 3+clog2(NUM_KEYS+1)+4 {octave,note,length}, rec_empty out 1, rec_full out 1, rec_ovf out 1.

Function
REQ-014 SHALL rising-edge-detect hit, oct_up, oct_down with one registered copy each; only edges act.
REQ-015 SHALL step octave +1 on oct_up edge and -1 on oct_down edge, saturating at OCT_MAX/OCT_MIN; both edges in one cycle leave octave unchanged.
REQ-016 SHALL run an FSM: IDLE, PLAY, GAP.
REQ-017 IDLE: hit edge with any note_key bit set SHALL latch note = lowest set index + 1, current octave and length, then enter PLAY next cycle; hit with no key SHALL be ignored.
REQ-018 Length SHALL decode from the highest set bit of length_key: bit0=1, bit1=2, bit2=4, bit3=8 units; none set = 2 units.
REQ-019 PLAY SHALL last exactly length*TICK_DIV cycles with play=1, then enter GAP; done SHALL pulse one cycle on the PLAY->GAP transition.
REQ-020 GAP SHALL last GAP_CYC cycles with play=0, then IDLE; note/length hold their values through GAP.
REQ-021 A valid hit edge in PLAY or GAP SHALL restart PLAY with the newly latched note and reset duration counter (retrigger); no done pulse is generated for the cut note.
REQ-022 Octave changes during PLAY SHALL not alter the latched octave of the sounding note.
REQ-023 led SHALL be one-hot of the latched key while play=1, else 0.
REQ-024 en=0 SHALL force IDLE, play=0, led=0, note=0, octave=OCT_INIT synchronously, and ignore all edges; the record buffer is retained.

Reset
REQ-025 rst_n=0 SHALL asynchronously set FSM=IDLE, octave=OCT_INIT, note=0, length=0, play=0, led=0, done=0, edge registers=0, record buffer empty, rec_ovf=0.
REQ-026 Reset mid-note SHALL abort without a done pulse.

Configuration
REQ-027 Macro FREE_PLAY_REC_EN defined: each accepted strike (REQ-017/021) SHALL push {octave,note,length} into a REC_DEPTH FIFO; rec_rd with !rec_empty pops, rec_data shows head (first-word-fall-through); push when full drops the entry and sets sticky rec_ovf; simultaneous push and pop when full SHALL both succeed.
REQ-028 Macro FREE_PLAY_REC_EN undefined: no FIFO storage; rec_empty=1, rec_full=0, rec_ovf=0, rec_data=0, rec_rd ignored.

Verification (TICK_DIV=4, GAP_CYC=3)
REQ-029 note_key=0b0000100, length_key=0b0010, hit edge -> note=3, play=1 for 8 cycles, done pulse, play=0 for 3 cycles, back to IDLE.
REQ-030 From octave 4: five oct_up edges -> octave 7; oct_up and oct_down same cycle -> unchanged.
REQ-031 Second hit 3 cycles into PLAY with key 0 -> note=1, counter restarts, exactly one done pulse total.
REQ-032 en dropped mid-PLAY -> play=0, led=0, octave=4 next cycle; hit while en=0 ignored.
REQ-033 With FREE_PLAY_REC_EN, REC_DEPTH=4: five strikes -> rec_full=1, rec_ovf=1; four rec_rd pops return the first four entries in order, then rec_empty=1.
